// File: rtl/lpm_arb_pkg.sv
// Shared types and helpers for the lookup request arbiter.
//   LPM_DATA_W   : default request/response payload width
//   LPM_N_REQ    : default number of clients
//   tag_t        : client id type for the default client count
//   lpm_onehot   : client id -> one-hot strobe (up to 8 clients)
//   lpm_rr_pick  : round-robin search for the first full slot from a pointer
package lpm_arb_pkg;

  localparam int LPM_DATA_W = 128;
  localparam int LPM_N_REQ  = 4;

  typedef logic [$clog2(LPM_N_REQ)-1:0] tag_t;

  function automatic logic [7:0] lpm_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  // Returns the first set bit of full scanning ptr, ptr+1, ... mod n.
  // With no bit set the pointer itself comes back; callers gate on |full.
  function automatic logic [2:0] lpm_rr_pick(input logic [7:0] full,
                                             input logic [2:0] ptr,
                                             input int unsigned n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < 32'd8; k++) begin
      idx = (32'(ptr) + k) % n;
      if ((k < n) && !found && full[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/lpm_req_slot.sv
// One client's input slot: a single-entry full bit plus payload register,
// and the credit counter of issued-but-unanswered requests.
//   enq_i / enq_data_i : enqueue fire and payload
//   drain_i            : slot word pushed downstream this cycle (issues a credit)
//   dec_i              : response delivered to this client (returns a credit)
//   rdy_o              : slot empty and credits available
//   full_o, data_o     : slot state for the scheduler
//   cnt_zero_o         : no request outstanding (a response now is an error)
module lpm_req_slot #(
  parameter  int DATA_W  = 128,
  parameter  int MAX_OUT = 2,
  localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enq_i,
  input  logic [DATA_W-1:0] enq_data_i,
  input  logic              drain_i,
  input  logic              dec_i,
  output logic              rdy_o,
  output logic              full_o,
  output logic              cnt_zero_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state for slot occupancy, payload and credit count.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    // Enqueue is only possible while empty, so it never collides with a drain.
    if (drain_i) begin
      full_d = 1'b0;
    end else if (enq_i) begin
      full_d = 1'b1;
      data_d = enq_data_i;
    end else begin
      full_d = full_q;
    end
    // Issue and response in the same cycle cancel out.
    case ({drain_i, dec_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Slot state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      full_q <= 1'b0;
      data_q <= {DATA_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdy_o      = !full_q && (cnt_q < CNT_W'(MAX_OUT));
  assign full_o     = full_q;
  assign cnt_zero_o = (cnt_q == {CNT_W{1'b0}});
  assign data_o     = data_q;

endmodule

// File: rtl/lpm_req_arbiter.sv
// Shares one downstream request channel among N_REQ lookup clients.
// Full client slots are drained round-robin, each word tagged with its client
// id; tagged responses are steered back to the owning client, and per-client
// credits cap in-flight lookups.
//   req_enq_*  : per-client enqueue (ENA/RDY vectors, packed payloads)
//   out_enq_*  : tagged word {tag, payload} pushed downstream
//   rsp_enq_*  : tagged response from the engine
//   cli_rsp_*  : one-hot delivery strobe and broadcast payload to clients
//   err        : sticky protocol error (bad tag or response without credit)
module lpm_req_arbiter
  import lpm_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int DATA_W  = LPM_DATA_W,
  parameter  int MAX_OUT = 2,
  localparam int TAG_W   = $clog2(N_REQ)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        req_enq_ena,
  input  logic [N_REQ*DATA_W-1:0] req_enq_v,
  output logic [N_REQ-1:0]        req_enq_rdy,
  output logic                    out_enq_ena,
  output logic [TAG_W+DATA_W-1:0] out_enq_v,
  input  logic                    out_enq_rdy,
  input  logic                    rsp_enq_ena,
  input  logic [DATA_W-1:0]       rsp_enq_v,
  input  logic [TAG_W-1:0]        rsp_enq_tag,
  output logic                    rsp_enq_rdy,
  output logic [N_REQ-1:0]        cli_rsp_ena,
  output logic [DATA_W-1:0]       cli_rsp_v,
  input  logic [N_REQ-1:0]        cli_rsp_rdy,
  output logic                    err
);

  logic [N_REQ-1:0]  full_s;
  logic [N_REQ-1:0]  rdy_s;
  logic [N_REQ-1:0]  zero_s;
  logic [N_REQ-1:0]  dec_s;
  logic [DATA_W-1:0] slot_data_s [N_REQ];
  logic [2:0]        pick_s;
  logic [TAG_W-1:0]  grant_s;
  logic              out_fire_s;
  logic              rsp_fire_s;
  logic [7:0]        tag_oh_s;
  logic [7:0]        deliver_s;
  logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              err_q, err_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    lpm_req_slot #(
      .DATA_W  (DATA_W),
      .MAX_OUT (MAX_OUT)
    ) u_slot (
      .CLK        (CLK),
      .RST        (RST),
      .enq_i      (req_enq_ena[i] & rdy_s[i]),
      .enq_data_i (req_enq_v[i*DATA_W +: DATA_W]),
      .drain_i    (out_fire_s & (grant_s == TAG_W'(i))),
      .dec_i      (dec_s[i]),
      .rdy_o      (rdy_s[i]),
      .full_o     (full_s[i]),
      .cnt_zero_o (zero_s[i]),
      .data_o     (slot_data_s[i])
    );
  end

  // Round-robin grant, downstream push and pointer advance.
  always_comb begin
    pick_s  = lpm_rr_pick(8'(full_s), 3'(rr_ptr_q), N_REQ);
    grant_s = TAG_W'(pick_s);
    // No push in a reset cycle: the slot contents are being discarded.
    out_fire_s = (|full_s) & out_enq_rdy & !RST;
    if (out_fire_s) begin
      rr_ptr_d = (grant_s == TAG_W'(N_REQ - 1)) ? {TAG_W{1'b0}} : grant_s + TAG_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Response steering: deliver only to a client that has a credit outstanding;
  // anything else (zero credit, tag beyond N_REQ) is flagged and dropped.
  always_comb begin
    rsp_fire_s = rsp_enq_ena & rsp_enq_rdy;
    tag_oh_s   = lpm_onehot(3'(rsp_enq_tag));
    if (rsp_fire_s) begin
      deliver_s = tag_oh_s & 8'(~zero_s);
    end else begin
      deliver_s = 8'b0000_0000;
    end
    dec_s = N_REQ'(deliver_s);
    if (rsp_fire_s && (dec_s == {N_REQ{1'b0}})) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Scheduler pointer and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q <= {TAG_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign req_enq_rdy = rdy_s;
  assign out_enq_ena = out_fire_s;
  assign out_enq_v   = {grant_s, slot_data_s[grant_s]};
  assign rsp_enq_rdy = &cli_rsp_rdy;
  assign cli_rsp_ena = dec_s;
  assign cli_rsp_v   = rsp_enq_v;
  assign err         = err_q;

endmodule
